lcd_scanout: RTL

//  Consumer end of the renderer's frame output. After the renderer flags

---
 rtl/lcd_scanout_if.sv | 29 ++
 rtl/lcd_scanout.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/lcd_scanout_if.sv
// Frame-buffer read port and pixel stream shared by the scan-out reader and its neighbours.
interface lcd_scanout_if #(
  parameter int PIX_BITS = 2
);
  logic                fb_rd_en;
  logic [7:0]          fb_rd_x;
  logic [7:0]          fb_rd_y;
  logic [PIX_BITS-1:0] fb_rd_data;
  logic                pix_valid;
  logic                pix_ready;
  logic [PIX_BITS-1:0] pix_data;
  logic                pix_sof;
  logic                pix_eol;
  logic                pix_eof;

  modport master (
    output fb_rd_en, fb_rd_x, fb_rd_y,
    input  fb_rd_data,
    output pix_valid, pix_data, pix_sof, pix_eol, pix_eof,
    input  pix_ready
  );

  modport slave (
    input  fb_rd_en, fb_rd_x, fb_rd_y,
    output fb_rd_data,
    input  pix_valid, pix_data, pix_sof, pix_eol, pix_eof,
    output pix_ready
  );
endinterface

// File: rtl/lcd_scanout.sv
// Walks a finished LCD frame buffer in raster order and streams shades over valid/ready.
module lcd_scanout #(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 144,
  parameter int PIX_BITS   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          render_complete,
  lcd_scanout_if.master bus,
  output logic          busy,
  output logic          frame_done,
  output logic          frame_dropped
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [7:0] Y_LAST = 8'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;
  typedef struct packed { logic sof; logic eol; logic eof; } tag_t;
  typedef struct packed { logic [PIX_BITS-1:0] data; tag_t tag; } entry_t;

  state_e        state_q, state_d;
  logic [7:0]    x_q, x_d, y_q, y_d;
  logic          inflight_q, inflight_d;
  tag_t          tag_q, tag_d;
  entry_t        mem_q [FIFO_DEPTH];
  entry_t        mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rc_q, rc_d;
  logic          frame_done_q, frame_done_d;
  logic          frame_dropped_q, frame_dropped_d;

  logic   rd_en, last_rd, push, pop, valid, eof_pop;
  entry_t head;

  // FSM outputs and read issue: room is judged on occupancy before this cycle's pop
  always_comb begin
    busy  = (state_q != IDLE);
    rd_en = (state_q == FETCH) &&
            (({1'b0, count_q} + (CW+1)'(inflight_q)) < (CW+1)'(FIFO_DEPTH));
  end

  // Buffer head and handshake decode
  always_comb begin
    head    = mem_q[rd_ptr_q];
    valid   = (count_q != '0);
    pop     = valid && bus.pix_ready;
    push    = inflight_q;
    last_rd = rd_en && (x_q == X_LAST) && (y_q == Y_LAST);
    eof_pop = pop && head.tag.eof;
  end

  // FSM next state; popping the eof entry implies the buffer empties with nothing in flight
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (render_complete) state_d = FETCH;
      FETCH:   if (last_rd)         state_d = DRAIN;
      DRAIN:   if (eof_pop)         state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Address walk, in-flight tags, output buffer and pulse generation
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (rd_en) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 8'd1;
      end else begin
        x_d = x_q + 8'd1;
      end
    end
    inflight_d = rd_en;
    tag_d      = tag_q;
    if (rd_en) tag_d = '{sof: (x_q == '0) && (y_q == '0), eol: (x_q == X_LAST), eof: last_rd};

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{data: bus.fb_rd_data, tag: tag_q};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    rc_d            = render_complete;
    frame_done_d    = eof_pop;
    frame_dropped_d = busy && render_complete && !rc_q;
  end

  // Control state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= IDLE;
      x_q             <= '0;
      y_q             <= '0;
      inflight_q      <= 1'b0;
      tag_q           <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      rc_q            <= 1'b0;
      frame_done_q    <= 1'b0;
      frame_dropped_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      x_q             <= x_d;
      y_q             <= y_d;
      inflight_q      <= inflight_d;
      tag_q           <= tag_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      rc_q            <= rc_d;
      frame_done_q    <= frame_done_d;
      frame_dropped_q <= frame_dropped_d;
    end
  end

  // Buffer storage needs no reset; it is only observed through a non-zero count
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // The issue rule must never let a push land on a full buffer
  always_ff @(posedge clk) begin
    if (reset && push && !pop) assert (count_q != CW'(FIFO_DEPTH));
  end

  // Stream outputs gated to zero while the buffer is empty
  always_comb begin
    bus.fb_rd_en  = rd_en;
    bus.fb_rd_x   = x_q;
    bus.fb_rd_y   = y_q;
    bus.pix_valid = valid;
    bus.pix_data  = valid ? head.data    : '0;
    bus.pix_sof   = valid ? head.tag.sof : 1'b0;
    bus.pix_eol   = valid ? head.tag.eol : 1'b0;
    bus.pix_eof   = valid ? head.tag.eof : 1'b0;
    frame_done    = frame_done_q;
    frame_dropped = frame_dropped_q;
  end
endmodule
